// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter/detector path:
// FSM state encoding and the frame pattern both ends agree on.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_FIN   = 2'd3
    } tx_state_t;

    localparam logic [3:0] PAT_DEFAULT = 4'b1001;
    localparam logic [3:0] PAT_DETECT  = 4'b1001;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Start/ready request bus and serial output group of the pattern transmitter.
interface seq_pattern_tx_if #(
    parameter int W     = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic [W-1:0]     pat_in;
    logic             use_def;
    logic [CNT_W-1:0] rep_in;
    logic             abort;
    logic             ready;
    logic             ser_out;
    logic             ser_en;
    logic             busy;
    logic             done;

    modport master (
        output start, pat_in, use_def, rep_in, abort,
        input  ready, ser_out, ser_en, busy, done
    );

    modport slave (
        input  start, pat_in, use_def, rep_in, abort,
        output ready, ser_out, ser_en, busy, done
    );
endinterface

// File: rtl/seq_shift_reg.sv
// W-bit parallel-load shift register, shifting toward the MSB; msb_o is the next bit out.
module seq_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] din_i,
    output logic         msb_o
);
    logic [W-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= din_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[W-2:0], 1'b0};
        end
    end

    assign msb_o = sr_q[W-1];
endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured W-bit pattern MSB-first, rep_in times,
// with GAP idle-zero cycles between repetitions.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int             W       = 4,
    parameter int             CNT_W   = 4,
    parameter int             GAP     = 1,
    parameter logic [W-1:0]   DEF_PAT = PAT_DEFAULT
) (
    input logic            clk,
    input logic            rst,
    seq_pattern_tx_if.slave bus
);
    localparam int BW = $clog2(W);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    tx_state_t        state_q, state_d;
    logic [W-1:0]     pat_q, pat_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             ready_q, ready_d;
    logic             busy_q;
    logic             ser_out_q, ser_out_d;
    logic             ser_en_q, ser_en_d;
    logic             done_q, done_d;

    logic             sr_load, sr_shift, sr_msb;
    logic [W-1:0]     sr_din;
    logic [W-1:0]     pat_sel;

    assign pat_sel = bus.use_def ? DEF_PAT : bus.pat_in;

    // The shift register holds only the bits still to come; the bit on the line lives in ser_out_q.
    seq_shift_reg #(.W(W)) u_sr (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .din_i   (sr_din),
        .msb_o   (sr_msb)
    );

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        rep_d     = rep_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ready_d   = ready_q;
        ser_out_d = 1'b0;
        ser_en_d  = 1'b0;
        done_d    = 1'b0;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sr_din    = {pat_q[W-2:0], 1'b0};

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pat_d   = pat_sel;
                    rep_d   = bus.rep_in;
                    ready_d = 1'b0;
                    if (bus.rep_in != '0) begin
                        state_d   = S_SHIFT;
                        ser_out_d = pat_sel[W-1];
                        ser_en_d  = 1'b1;
                        sr_load   = 1'b1;
                        sr_din    = {pat_sel[W-2:0], 1'b0};
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_SHIFT: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else if (bit_cnt_q == BW'(W - 1)) begin
                    if (rep_q != CNT_W'(1)) begin
                        rep_d = rep_q - CNT_W'(1);
                        if (GAP == 0) begin
                            ser_out_d = pat_q[W-1];
                            ser_en_d  = 1'b1;
                            sr_load   = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            state_d   = S_GAP;
                            gap_cnt_d = '0;
                        end
                    end else begin
                        rep_d   = '0;
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end
                end else begin
                    ser_out_d = sr_msb;
                    ser_en_d  = 1'b1;
                    sr_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else if (gap_cnt_q == GW'(GAP - 1)) begin
                    state_d   = S_SHIFT;
                    ser_out_d = pat_q[W-1];
                    ser_en_d  = 1'b1;
                    sr_load   = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                done_d  = !bus.abort;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            rep_q     <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            ser_out_q <= 1'b0;
            ser_en_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            rep_q     <= rep_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ready_q   <= ready_d;
            busy_q    <= ~ready_d;
            ser_out_q <= ser_out_d;
            ser_en_q  <= ser_en_d;
            done_q    <= done_d;
        end
    end

    assign bus.ready   = ready_q;
    assign bus.busy    = busy_q;
    assign bus.ser_out = ser_out_q;
    assign bus.ser_en  = ser_en_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: expected serial bits and done pulses are queued with their
// cycle stamps at stimulus time and retired by a monitor watching both DUT instances.
module tb_seq_pattern_tx;
    localparam int W     = 4;
    localparam int CNT_W = 4;

    typedef struct {
        int cyc;
        bit is_done;
        bit val;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[2][$];

    logic [3:0] det_sh   = 4'b0;
    int         det_n    = 0;
    int         det_hits = 0;

    seq_pattern_tx_if #(.W(W), .CNT_W(CNT_W)) b0 ();
    seq_pattern_tx_if #(.W(W), .CNT_W(CNT_W)) b1 ();

    seq_pattern_tx #(.W(W), .CNT_W(CNT_W), .GAP(1), .DEF_PAT(4'b1001)) dut0 (
        .clk (clk),
        .rst (rst_n),
        .bus (b0)
    );

    seq_pattern_tx #(.W(W), .CNT_W(CNT_W), .GAP(0), .DEF_PAT(4'b1001)) dut1 (
        .clk (clk),
        .rst (rst_n),
        .bus (b1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Non-overlapping 1001 detector on the GAP=0 instance's serial line.
    always @(negedge clk) begin
        if (rst_n && b1.ser_en) begin
            if (det_n >= 3 && {det_sh[2:0], b1.ser_out} == 4'b1001) begin
                det_hits <= det_hits + 1;
                det_n    <= 0;
            end else begin
                det_n <= det_n + 1;
            end
            det_sh <= {det_sh[2:0], b1.ser_out};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int d, input logic [3:0] pat, input int gap, input int e0,
                            input int nbits, input bit wdone, input int reps);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            e.cyc     = e0 + (i / W) * (W + gap) + (i % W);
            e.is_done = 1'b0;
            e.val     = pat[W-1-(i % W)];
            sb[d].push_back(e);
        end
        if (wdone) begin
            e.cyc     = (reps == 0) ? e0 + 1 : e0 + reps * W + (reps - 1) * gap;
            e.is_done = 1'b1;
            e.val     = 1'b0;
            sb[d].push_back(e);
        end
    endtask

    task automatic mon(input int d, input logic en, input logic so, input logic dn);
        exp_t e;
        while (sb[d].size() > 0 && sb[d][0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_d%0d: got nothing at cyc %0d want %s at cyc %0d",
                     d, cyc, sb[d][0].is_done ? "done" : "bit", sb[d][0].cyc);
            e = sb[d].pop_front();
        end
        if (en) begin
            if (sb[d].size() == 0 || sb[d][0].is_done || sb[d][0].cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bit_d%0d: got ser_en=1 at cyc %0d want no bit", d, cyc);
            end else begin
                e = sb[d].pop_front();
                chk($sformatf("bit_d%0d_c%0d", d, cyc), so, e.val);
            end
        end
        if (dn) begin
            if (sb[d].size() == 0 || !sb[d][0].is_done || sb[d][0].cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done_d%0d: got done=1 at cyc %0d want no done", d, cyc);
            end else begin
                e = sb[d].pop_front();
                checks++;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            mon(0, b0.ser_en, b0.ser_out, b0.done);
            mon(1, b1.ser_en, b1.ser_out, b1.done);
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic start_xfer(input int d, input logic [3:0] pin, input logic ud,
                              input logic [3:0] rep, input logic [3:0] epat, input int gap,
                              input int nbits, input bit wdone, output int e0);
        @(negedge clk);
        e0 = cyc + 1;
        push_exp(d, epat, gap, e0, nbits, wdone, int'(rep));
        if (d == 0) begin
            b0.start = 1'b1; b0.pat_in = pin; b0.use_def = ud; b0.rep_in = rep;
        end else begin
            b1.start = 1'b1; b1.pat_in = pin; b1.use_def = ud; b1.rep_in = rep;
        end
        @(negedge clk);
        if (d == 0) b0.start = 1'b0;
        else        b1.start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        b0.start = 1'b0; b0.pat_in = '0; b0.use_def = 1'b0; b0.rep_in = '0; b0.abort = 1'b0;
        b1.start = 1'b0; b1.pat_in = '0; b1.use_def = 1'b0; b1.rep_in = '0; b1.abort = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready",   b0.ready,   1);
        chk("rst_busy",    b0.busy,    0);
        chk("rst_ser_en",  b0.ser_en,  0);
        chk("rst_ser_out", b0.ser_out, 0);
        chk("rst_done",    b0.done,    0);
        chk("rst_ready1",  b1.ready,   1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Default pattern, one repetition: 1,0,0,1 then done on the 5th cycle
        start_xfer(0, 4'b0000, 1'b1, 4'd1, 4'b1001, 1, 4, 1'b1, e0);
        chk("def_ready_low", b0.ready, 0);
        chk("def_busy_high", b0.busy,  1);
        wait_cyc(e0 + 4);
        chk("def_done_ready", b0.ready, 1);
        chk("def_done_busy",  b0.busy,  0);
        wait_cyc(e0 + 6);

        // 1011 x3 with one gap cycle: done on cycle 15
        start_xfer(0, 4'b1011, 1'b0, 4'd3, 4'b1011, 1, 12, 1'b1, e0);
        wait_cyc(e0 + 4);
        chk("gap_ser_en",  b0.ser_en,  0);
        chk("gap_ser_out", b0.ser_out, 0);
        wait_cyc(e0 + 14);
        chk("rep3_done", b0.done, 1);
        wait_cyc(e0 + 16);

        // GAP=0 instance: 10011001 back-to-back, detector must fire twice
        start_xfer(1, 4'b0110, 1'b1, 4'd2, 4'b1001, 0, 8, 1'b1, e0);
        wait_cyc(e0 + 8);
        chk("b2b_done", b1.done, 1);
        wait_cyc(e0 + 10);
        chk("b2b_detect_hits", det_hits, 2);

        // Maximum repetition count: 15 patterns, no wrap
        start_xfer(1, 4'b1010, 1'b0, 4'd15, 4'b1010, 0, 60, 1'b1, e0);
        wait_cyc(e0 + 59);
        chk("max_busy_last_bit", b1.busy, 1);
        wait_cyc(e0 + 60);
        chk("max_ready", b1.ready, 1);
        wait_cyc(e0 + 62);

        // rep_in = 0: one busy cycle then done
        start_xfer(0, 4'b1111, 1'b0, 4'd0, 4'b1111, 1, 0, 1'b1, e0);
        chk("rep0_ready_low", b0.ready, 0);
        wait_cyc(e0 + 1);
        chk("rep0_ready", b0.ready, 1);
        chk("rep0_done",  b0.done,  1);
        wait_cyc(e0 + 3);

        // start held through the done cycle: immediate re-acceptance with new pat_in
        @(negedge clk);
        e0 = cyc + 1;
        push_exp(0, 4'b1100, 1, e0,     4, 1'b1, 1);
        push_exp(0, 4'b0011, 1, e0 + 5, 4, 1'b1, 1);
        b0.start = 1'b1; b0.pat_in = 4'b1100; b0.use_def = 1'b0; b0.rep_in = 4'd1;
        @(negedge clk);
        b0.pat_in = 4'b0011;
        wait_cyc(e0 + 4);
        chk("hold_done_ready", b0.ready, 1);
        wait_cyc(e0 + 5);
        chk("hold_reaccept_ready", b0.ready, 0);
        b0.start = 1'b0;
        wait_cyc(e0 + 11);

        // Abort on the 3rd bit of repetition 2; a start while busy must be ignored
        start_xfer(0, 4'b1101, 1'b0, 4'd4, 4'b1101, 1, 7, 1'b0, e0);
        wait_cyc(e0 + 1);
        b0.start = 1'b1; b0.pat_in = 4'b0000; b0.use_def = 1'b1; b0.rep_in = 4'd1;
        wait_cyc(e0 + 2);
        b0.start = 1'b0;
        wait_cyc(e0 + 7);
        b0.abort = 1'b1;
        wait_cyc(e0 + 8);
        b0.abort = 1'b0;
        chk("abort_ready",  b0.ready,  1);
        chk("abort_busy",   b0.busy,   0);
        chk("abort_ser_en", b0.ser_en, 0);
        chk("abort_done",   b0.done,   0);
        wait_cyc(e0 + 30);

        // Asynchronous reset during the 3rd bit of a transfer
        start_xfer(0, 4'b0110, 1'b0, 4'd1, 4'b0110, 1, 2, 1'b0, e0);
        wait_cyc(e0 + 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready",   b0.ready,   1);
        chk("mid_rst_busy",    b0.busy,    0);
        chk("mid_rst_ser_en",  b0.ser_en,  0);
        chk("mid_rst_ser_out", b0.ser_out, 0);
        chk("mid_rst_done",    b0.done,    0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_ready", b0.ready, 1);
        start_xfer(0, 4'b0110, 1'b0, 4'd2, 4'b0110, 1, 8, 1'b1, e0);
        wait_cyc(e0 + 12);

        chk("sb0_empty", sb[0].size(), 0);
        chk("sb1_empty", sb[1].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: accepts a W-bit pattern and a repetition count over a start/ready handshake.
- Shifts the pattern out MSB-first on a one-bit serial line, once per repetition.
- Inserts GAP idle-zero cycles between repetitions so a downstream non-overlapping detector sees clean frames.
- Serves as the stimulus/source end of the team's serial sequence-detector path (default pattern 1001).

Parameters:
- W, 4, pattern width in bits (≥2).
- CNT_W, 4, width of the repetition count.
- GAP, 1, idle cycles (ser_out=0, ser_en=0) between repetitions; 0 allowed.
- DEF_PAT, 4'b1001, pattern sent when use_def=1 (width W).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  transmit request; accepted only when start=1 and ready=1 at a rising edge.
- pat_in  in  W  pattern to send, captured at acceptance.
- use_def  in  1  1 = send DEF_PAT and ignore pat_in; captured at acceptance.
- rep_in  in  CNT_W  number of repetitions, captured at acceptance; 0 = send nothing.
- abort  in  1  synchronous abort, ignored in IDLE.
- ready  out  1  1 = block can accept start.
- ser_out  out  1  serial data, MSB first.
- ser_en  out  1  1 = ser_out carries a pattern bit this cycle.
- busy  out  1  1 = transfer in progress (equals ~ready).
- done  out  1  one-cycle pulse at the normal end of a transfer.

Behaviour:
- All outputs are registered.
- Reset (rst=0, async): state IDLE, ready=1, busy=0, ser_out=0, ser_en=0, done=0; shift register, bit counter and repetition counter cleared.
- States: IDLE, SHIFT, GAP, FIN.
- IDLE:
  - Accept at edge E0 when start=1: capture pattern (DEF_PAT if use_def=1), capture rep_in, set ready=0, busy=1.
  - If rep_in≠0 at E0: go to SHIFT, ser_out<=pattern[W-1], ser_en<=1, so the first bit is visible in the cycle after E0 (latency 1).
  - If rep_in=0 at E0: go to FIN, ser_en stays 0.
  - When start=0, stay in IDLE; done drops to 0 at the next edge.
- SHIFT:
  - Each edge presents the next lower bit; ser_en=1 for exactly W consecutive cycles per repetition.
  - At the edge following the LSB cycle:
    - If repetitions remain and GAP>0: go to GAP; ser_out=0, ser_en=0.
    - If repetitions remain and GAP=0: reload the pattern and present its MSB immediately (back-to-back, no bubble).
    - If this was the last repetition: go to IDLE, ser_en=0, ser_out=0, ready=1, busy=0, done=1.
- GAP:
  - Lasts exactly GAP cycles with ser_en=0, ser_out=0.
  - At the edge ending the GAP, go to SHIFT and present the MSB of the reloaded pattern.
- FIN (rep_in=0 path only): one cycle with ready=0. At the next edge go to IDLE, ready=1, done=1.
- done:
  - High for exactly one cycle, coincident with the first ready=1 cycle after the transfer.
  - A start sampled during that cycle is accepted normally; done then clears and ready drops.
- abort=1 in SHIFT/GAP/FIN at an edge: go to IDLE, ready=1, ser_en=0, ser_out=0, done=0; the partial pattern is truncated and no done pulse is produced.
- pat_in, use_def and rep_in changes while busy have no effect. start while busy is ignored, not queued.
- Repetition counter:
  - Decrements once per completed pattern.
  - No wrap: the maximum rep_in = 2^CNT_W−1 sends exactly that many patterns.
- Total cycles from E0 to the done cycle for R≥1: R·W + (R−1)·GAP + 1.
- Asserting rst mid-transfer forces the reset values immediately, independent of clk.

Decomposition:
- Shared package seq_pkg holds:
  - The state encoding constants (IDLE, SHIFT, GAP, FIN).
  - The default pattern constant 4'b1001.
  - The detector pattern constant, so transmitter and detector share one definition.
- One natural sub-module, seq_shift_reg: a W-bit parallel-load, MSB-first shift register with a load/shift enable.
- FSM and counters stay in seq_pattern_tx.

Test Plan:
- Reset mid-SHIFT (rst low after the 2nd bit) -> outputs return to reset values immediately; after release, ready=1 and a new start sends the full pattern.
- use_def=1, rep_in=1, W=4 -> ser_en=1 for 4 cycles with ser_out=1,0,0,1 starting the cycle after acceptance; done=1 on the 5th cycle after E0; ready=1 from that same cycle.
- pat_in=4'b1011, rep_in=3, GAP=1 -> serial stream 1011 0 1011 0 1011 (ser_en=0 on the gap cycles); done on cycle 15 after E0.
- GAP=0, DEF_PAT, rep_in=2 -> 10011001 with ser_en continuously high for 8 cycles; a downstream non-overlapping 1001 detector flags twice.
- rep_in=0 -> ser_en never asserts; ready=0 for one cycle; done at cycle 2 after E0. Separately, start held high through the done cycle -> immediate re-acceptance with no idle cycle.
- abort asserted at the 3rd bit of repetition 2 (rep_in=4) -> ser_en=0 at the next cycle, ready=1, no done pulse; start asserted while busy earlier in the run is ignored.
